// File: rtl/alu_pkg.sv
// Shared definitions for the nibble-serial ALU: widths, select codes,
// sequencer state and the one-bit ALU slice.
package alu_pkg;

  localparam int ALU_SEL_W = 3;
  localparam int NIBBLE_W  = 4;

  localparam logic [ALU_SEL_W-1:0] ALU_ADD  = 3'd0;
  localparam logic [ALU_SEL_W-1:0] ALU_SUB  = 3'd1;
  localparam logic [ALU_SEL_W-1:0] ALU_AND  = 3'd2;
  localparam logic [ALU_SEL_W-1:0] ALU_OR   = 3'd3;
  localparam logic [ALU_SEL_W-1:0] ALU_XOR  = 3'd4;
  localparam logic [ALU_SEL_W-1:0] ALU_NOR  = 3'd5;
  localparam logic [ALU_SEL_W-1:0] ALU_NAND = 3'd6;
  localparam logic [ALU_SEL_W-1:0] ALU_PASSA = 3'd7;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } seq_state_e;

  // One-bit slice: returns {carry_out, y}.
  // SUB is a + ~b + cin; logic ops drive carry_out low.
  function automatic logic [1:0] alu1(
    input logic                 a,
    input logic                 b,
    input logic                 cin,
    input logic [ALU_SEL_W-1:0] sel
  );
    logic bb;
    logic y;
    logic co;
    bb = (sel == ALU_SUB) ? ~b : b;
    y  = 1'b0;
    co = 1'b0;
    case (sel)
      ALU_ADD, ALU_SUB: begin
        y  = a ^ bb ^ cin;
        co = (a & bb) | (cin & (a ^ bb));
      end
      ALU_AND:   y = a & b;
      ALU_OR:    y = a | b;
      ALU_XOR:   y = a ^ b;
      ALU_NOR:   y = ~(a | b);
      ALU_NAND:  y = ~(a & b);
      ALU_PASSA: y = a;
      default:   y = 1'b0;
    endcase
    return {co, y};
  endfunction

endpackage

// File: rtl/alu_nibble_seq_alu4.sv
// alu4: four alu1 slices rippled LSB to MSB.
// Ports: a_i/b_i nibbles, sel_i op, carry_i in; y_o result, carry_o out.
module alu4
  import alu_pkg::*;
(
  input  logic [NIBBLE_W-1:0]  a_i,
  input  logic [NIBBLE_W-1:0]  b_i,
  input  logic [ALU_SEL_W-1:0] sel_i,
  input  logic                 carry_i,
  output logic [NIBBLE_W-1:0]  y_o,
  output logic                 carry_o
);

  always_comb begin
    logic       c;
    logic [1:0] r;
    c   = carry_i;
    r   = 2'b00;
    y_o = '0;
    for (int i = 0; i < NIBBLE_W; i++) begin
      r      = alu1(a_i[i], b_i[i], c, sel_i);
      y_o[i] = r[0];
      c      = r[1];
    end
    carry_o = c;
  end

endmodule

// File: rtl/alu_nibble_seq.sv
// alu_nibble_seq: runs a W-bit op through one alu4, one nibble per clock.
// Ports: in_* operand handshake, out_* result handshake, clk/rst async.
module alu_nibble_seq
  import alu_pkg::*;
#(
  parameter int NIBBLES = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [4*NIBBLES-1:0]   in_a,
  input  logic [4*NIBBLES-1:0]   in_b,
  input  logic [ALU_SEL_W-1:0]   in_select,
  input  logic                   in_carry,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [4*NIBBLES-1:0]   out_result,
  output logic                   out_carry,
  output logic                   out_zero
);

  localparam int W     = NIBBLE_W * NIBBLES;
  localparam int CNT_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NIBBLES - 1);

  seq_state_e           state_q;
  logic [W-1:0]         a_sh_q;
  logic [W-1:0]         b_sh_q;
  logic [W-1:0]         res_sh_q;
  logic [ALU_SEL_W-1:0] sel_q;
  logic                 carry_q;
  logic [CNT_W-1:0]     cnt_q;

  logic [NIBBLE_W-1:0]  nib_y;
  logic                 nib_c;
  logic [W-1:0]         res_sh_d;

  alu4 u_alu4 (
    .a_i     (a_sh_q[NIBBLE_W-1:0]),
    .b_i     (b_sh_q[NIBBLE_W-1:0]),
    .sel_i   (sel_q),
    .carry_i (carry_q),
    .y_o     (nib_y),
    .carry_o (nib_c)
  );

  // New nibble enters at the top; after NIBBLES steps the
  // first nibble has walked down to bit 0.
  assign res_sh_d = W'({nib_y, res_sh_q} >> NIBBLE_W);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      a_sh_q   <= '0;
      b_sh_q   <= '0;
      res_sh_q <= '0;
      sel_q    <= '0;
      carry_q  <= 1'b0;
      cnt_q    <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (in_valid) begin
            a_sh_q   <= in_a;
            b_sh_q   <= in_b;
            sel_q    <= in_select;
            carry_q  <= in_carry;
            res_sh_q <= '0;
            cnt_q    <= '0;
            state_q  <= RUN;
          end
        end
        RUN: begin
          a_sh_q   <= a_sh_q >> NIBBLE_W;
          b_sh_q   <= b_sh_q >> NIBBLE_W;
          res_sh_q <= res_sh_d;
          carry_q  <= nib_c;
          cnt_q    <= cnt_q + 1'b1;
          if (cnt_q == CNT_LAST) begin
            state_q <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready   = (state_q == IDLE);
  assign out_valid  = (state_q == DONE);
  assign out_result = res_sh_q;
  assign out_carry  = carry_q;
  assign out_zero   = (res_sh_q == '0);

endmodule

// File: tb/tb_alu_nibble_seq.sv
// Directed bench for alu_nibble_seq (NIBBLES=4): latency, carry chain,
// backpressure, mid-run reset and back-to-back throughput.
module tb_alu_nibble_seq;
  import alu_pkg::*;

  localparam int N = 4;
  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_a;
  logic [W-1:0] in_b;
  logic [2:0]   in_select;
  logic         in_carry;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_result;
  logic         out_carry;
  logic         out_zero;

  int nerr = 0;
  int nchk = 0;

  alu_nibble_seq #(.NIBBLES(N)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_a       (in_a),
    .in_b       (in_b),
    .in_select  (in_select),
    .in_carry   (in_carry),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_carry  (out_carry),
    .out_zero   (out_zero)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  // Word-level reference: {carry, result}
  function automatic logic [16:0] model(input logic [15:0] a,
                                        input logic [15:0] b,
                                        input logic [2:0] s,
                                        input logic c);
    logic [16:0] r;
    case (s)
      ALU_ADD:   r = {1'b0, a} + {1'b0, b} + {16'b0, c};
      ALU_SUB:   r = {1'b0, a} + {1'b0, ~b} + {16'b0, c};
      ALU_AND:   r = {1'b0, a & b};
      ALU_OR:    r = {1'b0, a | b};
      ALU_XOR:   r = {1'b0, a ^ b};
      ALU_NOR:   r = {1'b0, ~(a | b)};
      ALU_NAND:  r = {1'b0, ~(a & b)};
      default:   r = {1'b0, a};
    endcase
    return r;
  endfunction

  task automatic run_op(input logic [15:0] a, input logic [15:0] b,
                        input logic [2:0] s, input logic c,
                        output int lat);
    chk("pre_rdy", 32'(in_ready), 32'd1);
    in_a = a; in_b = b; in_select = s; in_carry = c;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("lat", 32'(lat), 32'(N));
  endtask

  task automatic release_out;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("rel_vld", 32'(out_valid), 32'd0);
    chk("rel_rdy", 32'(in_ready), 32'd1);
  endtask

  logic [15:0] ta [8];
  logic [15:0] tb [8];
  logic        tc [8];
  logic [16:0] expq [$];

  initial begin
    int lat;
    int seen;
    int nacc;
    int ngot;
    int last;
    logic acc;

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    in_a = '0; in_b = '0; in_select = '0; in_carry = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b0;
    @(negedge clk);
    chk("rst_rdy", 32'(in_ready), 32'd1);
    chk("rst_vld", 32'(out_valid), 32'd0);
    chk("rst_res", 32'(out_result), 32'h0000);
    chk("rst_cy", 32'(out_carry), 32'd0);
    chk("rst_z", 32'(out_zero), 32'd1);

    run_op(16'h00FF, 16'h0001, ALU_ADD, 1'b0, lat);
    chk("add1_res", 32'(out_result), 32'h0100);
    chk("add1_cy", 32'(out_carry), 32'd0);
    chk("add1_z", 32'(out_zero), 32'd0);
    release_out();

    run_op(16'h0005, 16'h0003, ALU_SUB, 1'b1, lat);
    chk("sub_res", 32'(out_result), 32'h0002);
    chk("sub_cy", 32'(out_carry), 32'd1);
    release_out();

    run_op(16'hF0F0, 16'h0FF0, ALU_AND, 1'b0, lat);
    chk("and_res", 32'(out_result), 32'h00F0);
    chk("and_cy", 32'(out_carry), 32'd0);
    release_out();

    run_op(16'hFFFF, 16'h0001, ALU_ADD, 1'b0, lat);
    chk("add2_res", 32'(out_result), 32'h0000);
    chk("add2_cy", 32'(out_carry), 32'd1);
    chk("add2_z", 32'(out_zero), 32'd1);

    // Hold the result while in_valid toggles
    for (int i = 0; i < 10; i++) begin
      in_valid = i[0];
      in_a = 16'(i * 16'h1111);
      @(posedge clk); #1;
      chk("bp_res", 32'(out_result), 32'h0000);
      chk("bp_cy", 32'(out_carry), 32'd1);
      chk("bp_rdy", 32'(in_ready), 32'd0);
      chk("bp_vld", 32'(out_valid), 32'd1);
    end
    in_valid = 1'b0;
    release_out();
    @(posedge clk); #1;
    chk("bp_post_vld", 32'(out_valid), 32'd0);
    chk("bp_post_rdy", 32'(in_ready), 32'd1);

    // Reset during the second RUN cycle
    in_a = 16'h1111; in_b = 16'h2222;
    in_select = ALU_ADD; in_carry = 1'b0;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      if (out_valid) seen = 1;
      @(posedge clk); #1;
    end
    chk("mr_novld", 32'(seen), 32'd0);
    chk("mr_rdy", 32'(in_ready), 32'd1);
    chk("mr_res", 32'(out_result), 32'h0000);
    chk("mr_z", 32'(out_zero), 32'd1);

    run_op(16'h1234, 16'h1111, ALU_ADD, 1'b0, lat);
    chk("mr_add_res", 32'(out_result), 32'h2345);
    chk("mr_add_cy", 32'(out_carry), 32'd0);
    release_out();

    // Back-to-back, every select code
    for (int i = 0; i < 8; i++) begin
      ta[i] = 16'($urandom);
      tb[i] = 16'($urandom);
      tc[i] = 1'($urandom);
    end
    ta[0] = 16'hFFFF;
    tb[0] = 16'h0000;
    tc[0] = 1'b1;
    in_a = ta[0]; in_b = tb[0]; in_carry = tc[0];
    in_select = 3'd0;
    in_valid = 1'b1;
    out_ready = 1'b1;
    nacc = 0; ngot = 0; last = 0;
    for (int cyc = 0; cyc < 100 && ngot < 8; cyc++) begin
      @(negedge clk);
      if (out_valid) begin
        if (expq.size() == 0) begin
          chk("tp_extra", 32'd1, 32'd0);
        end else begin
          chk("tp_res", 32'(out_result), 32'(expq[0][15:0]));
          chk("tp_cy", 32'(out_carry), 32'(expq[0][16]));
          void'(expq.pop_front());
        end
        ngot++;
      end
      acc = in_ready && in_valid;
      if (acc) begin
        expq.push_back(model(in_a, in_b, in_select, in_carry));
        if (nacc > 0) chk("tp_gap", 32'(cyc - last), 32'd6);
        last = cyc;
        nacc++;
      end
      @(posedge clk); #1;
      if (acc) begin
        if (nacc < 8) begin
          in_a = ta[nacc]; in_b = tb[nacc]; in_carry = tc[nacc];
          in_select = 3'(nacc);
        end else begin
          in_valid = 1'b0;
        end
      end
    end
    chk("tp_n", 32'(ngot), 32'd8);
    out_ready = 1'b0;

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
